// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_mem_pkg
//  Description : Shared types and helpers for the MEM-stage data-memory
//                access unit: FSM state encoding, default RAM base address
//                and the byte-address to word-offset conversion.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1001_0000;

  // Word offset of a byte address relative to the RAM base. The caller
  // truncates the result to the RAM index width.
  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    logic [31:0] diff;
    diff = addr - base;
    return diff >> 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface   : mem_access_unit_if
//  Description : req/ack data RAM bus between the access unit and the RAM.
//  Signals     : mem_req, mem_we, mem_addr, mem_wdata  (master -> slave)
//                mem_ack, mem_rdata                    (slave  -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 10
);
  logic                      mem_req;
  logic                      mem_we;
  logic [RAM_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      mem_ack;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_timeout_counter
//  Description : Counts cycles spent waiting for a RAM ack. expired is high
//                on the TIMEOUT_CYCLES-th consecutive enabled cycle.
//  Ports       : clk, reset (async, high), clear, en -> expired
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic clear,
  input  wire logic en,
  output logic      expired
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  // First WAIT cycle sees count 0, so the last allowed cycle sees T-1.
  assign expired = en && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM-stage data-memory controller. Turns load/store requests
//                from EX/MEM into req/ack RAM transactions, stalls the
//                pipeline until completion, and flags misaligned accesses
//                and bus timeouts.
//  Ports       : clk, reset            clock, async active-high reset
//                in_Ctrl_MemRead/Write load / store in EX/MEM
//                in_ALU_Result         effective byte address
//                in_Write_Data         store data
//                bus (master)          RAM req/ack bus
//                out_RAM_Read_Data     registered load result
//                stall                 pipeline freeze
//                misaligned, bus_error one-cycle error pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter int          RAM_ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  in_Ctrl_MemRead,
  input  wire logic                  in_Ctrl_MemWrite,
  input  wire logic [DATA_WIDTH-1:0] in_ALU_Result,
  input  wire logic [DATA_WIDTH-1:0] in_Write_Data,
  mem_access_unit_if.master          bus,
  output logic [DATA_WIDTH-1:0]      out_RAM_Read_Data,
  output logic                       stall,
  output logic                       misaligned,
  output logic                       bus_error
);

  state_t                    state_q;
  logic                      mem_req_q;
  logic                      mem_we_q;
  logic [RAM_ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]     mem_wdata_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      misaligned_q;
  logic                      bus_error_q;

  logic                      access_d;
  logic                      aligned_d;
  logic [31:0]               offset_d;
  logic [RAM_ADDR_WIDTH-1:0] mem_addr_d;
  logic                      expired;
  logic                      w_unused_offset;

  assign access_d        = in_Ctrl_MemRead | in_Ctrl_MemWrite;
  assign aligned_d       = (in_ALU_Result[1:0] == 2'b00);
  assign offset_d        = word_offset(in_ALU_Result, BASE_ADDR);
  assign mem_addr_d      = offset_d[RAM_ADDR_WIDTH-1:0];
  assign w_unused_offset = ^offset_d[31:RAM_ADDR_WIDTH];

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != WAIT),
    .en     (state_q == WAIT),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access_d && !aligned_d) begin
            misaligned_q <= 1'b1;
          end else if (access_d) begin
            mem_req_q   <= 1'b1;
            // A simultaneous read+write is treated as a store.
            mem_we_q    <= in_Ctrl_MemWrite;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= in_Write_Data;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // ack takes priority over an expiry in the same cycle.
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              rdata_q <= bus.mem_rdata;
            end
            state_q <= DONE;
          end else if (expired) begin
            mem_req_q   <= 1'b0;
            rdata_q     <= '0;
            bus_error_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // EX/MEM advances at this edge; the finished access is not reissued.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by reset so an abandoned access releases the pipeline at once.
  assign stall = ~reset &
                 (((state_q == IDLE) & access_d & aligned_d) | (state_q == WAIT));

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign out_RAM_Read_Data = rdata_q;
  assign misaligned      = misaligned_q;
  assign bus_error       = bus_error_q;

endmodule
`default_nettype wire
